// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multicycle main control and the ALU-control decoder.
// States, opcodes, alu_op, alu_src_b and pc_source codes.
package mc_main_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EXE = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_ERR      = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) ||
           (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control bundle between the main control FSM and the datapath/memory.
// master = controller side, slave = datapath side.
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       mem_ack;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       bus_err;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ack,
    output pc_write, pc_write_cond, i_or_d,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, bus_err, state_o
  );

  modport slave (
    output opcode, mem_ack,
    input  pc_write, pc_write_cond, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, bus_err, state_o
  );
endinterface

// File: rtl/mc_main_control_mem_wait_timer.sv
// Memory wait counter: clear/inc with saturation, hit at LIMIT.
// LIMIT = 0 never hits.
module mc_mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam int unsigned CW =
    (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hit = (LIMIT != 0) && (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with memory ack timeout.
// Option: `ILLEGAL_OP_TRAP_EN parks illegal opcodes in TRAP.
module mc_main_control
  import mc_main_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_main_control_if.master bus
);

  state_e r_state;
  state_e w_next;
  logic   r_bus_err;
  logic   w_inc;
  logic   w_hit;

  // counter runs only while a memory state waits
  assign w_inc = is_mem_state(r_state) & ~bus.mem_ack;

  mc_mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (~w_inc),
    .i_inc (w_inc),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= r_bus_err | (w_inc & w_hit);
    end
  end

  assign bus.state_o = r_state;
  assign bus.bus_err = r_bus_err;

  always_comb begin
    w_next            = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_4;
        bus.ir_write  = bus.mem_ack;
        bus.pc_write  = bus.mem_ack;
        if (bus.mem_ack) w_next = S_DECODE;
        else if (w_hit)  w_next = S_ERR;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_RTYPE:     w_next = S_R_EXE;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXE;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next = (bus.opcode == OP_SW) ? S_MEM_WR
                                       : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ack) w_next = S_MEM_WB;
        else if (w_hit)  w_next = S_ERR;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ack) w_next = S_FETCH;
        else if (w_hit)  w_next = S_ERR;
      end
      S_R_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_FUNCT;
        w_next = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        w_next = S_FETCH;
      end
      S_ADDI_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_ERR, S_TRAP: w_next = r_state;
      default:       w_next = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control with an instruction-path model.
// Build with MEM_TIMEOUT = 4; honours ILLEGAL_OP_TRAP_EN.
module tb_mc_main_control;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_main_control_if bus();

  mc_main_control #(
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw;
    logic       irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       berr;
    logic [3:0] st;
  } ov_t;

  typedef struct {
    int   st;
    logic ack;
  } ent_t;

  ent_t pq[$];
  int   tests = 0;
  int   fails = 0;
  bit   err_m = 1'b0;

  // Expected outputs straight from the per-state output table
  function automatic ov_t model(int st, logic ack, bit berr);
    ov_t o;
    o = '0;
    o.st = 4'(st);
    o.berr = berr;
    case (st)
      0:  begin o.mr = 1; o.srcb = 2'b01;
                o.pcw = ack; o.irw = ack; end
      1:  o.srcb = 2'b11;
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  begin o.mr = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mw = 1; o.iord = 1; end
      6:  begin o.srca = 1; o.aluop = 2'b10; end
      7:  begin o.rw = 1; o.rdst = 1; end
      8:  begin o.srca = 1; o.aluop = 2'b01;
                o.pcwc = 1; o.pcsrc = 2'b01; end
      9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
      10: begin o.srca = 1; o.srcb = 2'b10; end
      11: o.rw = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic ov_t dut_out();
    ov_t o;
    o.pcw   = bus.pc_write;
    o.pcwc  = bus.pc_write_cond;
    o.iord  = bus.i_or_d;
    o.mr    = bus.mem_read;
    o.mw    = bus.mem_write;
    o.irw   = bus.ir_write;
    o.m2r   = bus.mem_to_reg;
    o.rdst  = bus.reg_dst;
    o.rw    = bus.reg_write;
    o.srca  = bus.alu_src_a;
    o.srcb  = bus.alu_src_b;
    o.aluop = bus.alu_op;
    o.pcsrc = bus.pc_source;
    o.berr  = bus.bus_err;
    o.st    = bus.state_o;
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Memory-state residency: d no-ack cycles then ack, or timeout
  task automatic add_mem(int st, int d, output bit ok);
    if (d <= TMO) begin
      repeat (d) pq.push_back('{st: st, ack: 1'b0});
      pq.push_back('{st: st, ack: 1'b1});
      ok = 1'b1;
    end else begin
      repeat (TMO + 1) pq.push_back('{st: st, ack: 1'b0});
      repeat (3) pq.push_back('{st: 12, ack: 1'($urandom)});
      ok = 1'b0;
    end
  endtask

  task automatic push(int st);
    pq.push_back('{st: st, ack: 1'($urandom)});
  endtask

  task automatic build(logic [5:0] op, int df, int dm);
    bit ok;
    pq.delete();
    add_mem(0, df, ok);
    if (!ok) return;
    push(1);
    case (op)
      6'b000000: begin push(6); push(7); end
      6'b100011: begin
        push(2); add_mem(3, dm, ok);
        if (ok) push(4);
      end
      6'b101011: begin push(2); add_mem(5, dm, ok); end
      6'b000100: push(8);
      6'b000010: push(9);
      6'b001000: begin push(10); push(11); end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        repeat (3) push(13);
`endif
      end
    endcase
  endtask

  task automatic run(string nm, logic [5:0] op,
                     int from, int upto);
    for (int i = from; i <= upto && i < pq.size(); i++) begin
      @(negedge clk);
      bus.opcode  = op;
      bus.mem_ack = pq[i].ack;
      if (pq[i].st == 12) err_m = 1'b1;
      #1;
      chk($sformatf("%s c%0d", nm, i), 32'(dut_out()),
          32'(model(pq[i].st, pq[i].ack, err_m)));
    end
  endtask

  task automatic instr(string nm, logic [5:0] op,
                       int df, int dm, int len);
    build(op, df, dm);
    chk({nm, " len"}, pq.size(), len);
    run(nm, op, 0, pq.size() - 1);
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    err_m = 1'b0;
    chk({nm, " rst"}, 32'(dut_out()), 32'(model(0, 0, 0)));
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.opcode = 6'd0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", bus.state_o, 0);
    chk("reset bus_err", bus.bus_err, 0);
    chk("reset vec", 32'(dut_out()), 32'(model(0, 0, 0)));
    @(posedge clk);
    #2 rst_n = 1'b1;

    instr("rtype", 6'b000000, 0, 0, 4);
    instr("addi",  6'b001000, 0, 0, 4);
    instr("lw",    6'b100011, 0, 0, 5);
    instr("sw",    6'b101011, 0, 0, 4);
    instr("beq",   6'b000100, 0, 0, 3);
    instr("j",     6'b000010, 0, 0, 3);
    instr("lw_w3", 6'b100011, 0, 3, 8);
    instr("sw_w2", 6'b101011, 2, 2, 8);
    instr("lw_w4", 6'b100011, 1, 4, 10);
    instr("f_w4",  6'b000000, 4, 0, 8);

    // reset dropped in the middle of R_EXE
    build(6'b000000, 0, 0);
    run("rmid", 6'b000000, 0, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid state", bus.state_o, 0);
    chk("rmid reg_write", bus.reg_write, 0);
    chk("rmid alu_op", bus.alu_op, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    chk("rel irw_pcw", {bus.ir_write, bus.pc_write}, 2'b11);
    run("rmid", 6'b000000, 1, pq.size() - 1);

    instr("f_to", 6'b000000, 5, 0, 8);
    #1 chk("f_to bus_err", bus.bus_err, 1);
    do_reset("f_to");

    instr("sw_to", 6'b101011, 0, 5, 11);
    do_reset("sw_to");

    instr("lw_to", 6'b100011, 0, 6, 11);
    do_reset("lw_to");

`ifdef ILLEGAL_OP_TRAP_EN
    instr("ill", 6'b111111, 0, 0, 5);
    @(posedge clk);
    #1 chk("ill state", bus.state_o, 13);
    do_reset("ill");
`else
    instr("ill", 6'b111111, 0, 0, 2);
    @(posedge clk);
    #1 chk("ill state", bus.state_o, 0);
`endif

    instr("post", 6'b000000, 0, 0, 4);
    instr("post_j", 6'b000010, 1, 0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
